// File: rtl/gate_pkg.sv
// Shared state enum, gate bit positions, output bundle and golden truth function
// for the two-input basic gate block and its vector checker.
package gate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned N_GATES = 7;
    localparam int unsigned N_VECS  = 4;

    localparam int unsigned G_AND  = 0;
    localparam int unsigned G_OR   = 1;
    localparam int unsigned G_NOT  = 2;
    localparam int unsigned G_NAND = 3;
    localparam int unsigned G_NOR  = 4;
    localparam int unsigned G_XOR  = 5;
    localparam int unsigned G_XNOR = 6;

    // Bit 0 is the AND output, bit 6 the XNOR output.
    typedef struct packed {
        logic g_xnor;
        logic g_xor;
        logic g_nor;
        logic g_nand;
        logic g_not;
        logic g_or;
        logic g_and;
    } gate_bundle_t;

    function automatic gate_bundle_t gate_expect(input logic a, input logic b);
        logic [N_GATES-1:0] v;
        v         = '0;
        v[G_AND]  = a & b;
        v[G_OR]   = a | b;
        v[G_NOT]  = ~a;
        v[G_NAND] = ~(a & b);
        v[G_NOR]  = ~(a | b);
        v[G_XOR]  = a ^ b;
        v[G_XNOR] = ~(a ^ b);
        return gate_bundle_t'(v);
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of the two-input gate block.
module gate_ref_model
    import gate_pkg::*;
(
    input  logic         i_a,
    input  logic         i_b,
    output gate_bundle_t o_expect_c
);

    assign o_expect_c = gate_expect(i_a, i_b);

endmodule

// File: rtl/gate_vector_checker.sv
// Drives the four (a,b) vectors into an external gate block, holds each for
// HOLD_CYCLES cycles and scores the sampled gate outputs against the golden model.
module gate_vector_checker
    import gate_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 5,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 a,
    output logic                 b,
    input  logic                 cand,
    input  logic                 cor,
    input  logic                 cnot,
    input  logic                 cnand,
    input  logic                 cnor,
    input  logic                 cxor,
    input  logic                 cxnor,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2:0]           err_count,
    output logic [N_VECS-1:0]    vec_fail,
    output logic [N_GATES-1:0]   gate_fail
);

    localparam int unsigned ERR_W = 3;
    localparam int unsigned VEC_W = 2;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_e               r_state,     w_state_nx;
    logic [CNT_W-1:0]     r_hold,      w_hold_nx;
    logic [VEC_W-1:0]     r_vec,       w_vec_nx;
    logic                 r_a,         w_a_nx;
    logic                 r_b,         w_b_nx;
    logic                 r_busy,      w_busy_nx;
    logic                 r_done,      w_done_nx;
    logic                 r_pass,      w_pass_nx;
    logic [ERR_W-1:0]     r_err,       w_err_nx;
    logic [N_VECS-1:0]    r_vec_fail,  w_vec_fail_nx;
    logic [N_GATES-1:0]   r_gate_fail, w_gate_fail_nx;

    gate_bundle_t         w_expect;
    gate_bundle_t         w_observed;
    logic [N_GATES-1:0]   w_mism;
    logic                 w_sample;

    gate_ref_model u_ref (
        .i_a        (r_a),
        .i_b        (r_b),
        .o_expect_c (w_expect)
    );

    assign w_observed = gate_bundle_t'({cxnor, cxor, cnor, cnand, cnot, cor, cand});
    assign w_mism     = w_expect ^ w_observed;
    // Last cycle of the hold window: gate outputs have settled for HOLD_CYCLES-1 cycles.
    assign w_sample   = (r_hold == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_hold      <= '0;
            r_vec       <= '0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err       <= '0;
            r_vec_fail  <= '0;
            r_gate_fail <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_hold      <= w_hold_nx;
            r_vec       <= w_vec_nx;
            r_a         <= w_a_nx;
            r_b         <= w_b_nx;
            r_busy      <= w_busy_nx;
            r_done      <= w_done_nx;
            r_pass      <= w_pass_nx;
            r_err       <= w_err_nx;
            r_vec_fail  <= w_vec_fail_nx;
            r_gate_fail <= w_gate_fail_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_hold_nx      = r_hold;
        w_vec_nx       = r_vec;
        w_a_nx         = r_a;
        w_b_nx         = r_b;
        w_busy_nx      = r_busy;
        w_done_nx      = r_done;
        w_pass_nx      = r_pass;
        w_err_nx       = r_err;
        w_vec_fail_nx  = r_vec_fail;
        w_gate_fail_nx = r_gate_fail;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nx     = ST_RUN;
                    w_hold_nx      = '0;
                    w_vec_nx       = '0;
                    w_a_nx         = 1'b0;
                    w_b_nx         = 1'b0;
                    w_busy_nx      = 1'b1;
                    w_done_nx      = 1'b0;
                    w_pass_nx      = 1'b0;
                    w_err_nx       = '0;
                    w_vec_fail_nx  = '0;
                    w_gate_fail_nx = '0;
                end
            end
            ST_RUN: begin
                if (!w_sample) begin
                    w_hold_nx = r_hold + CNT_W'(1);
                end else begin
                    w_gate_fail_nx = r_gate_fail | w_mism;
                    if (w_mism != '0) begin
                        w_vec_fail_nx[r_vec] = 1'b1;
                        w_err_nx             = r_err + ERR_W'(1);
                    end
                    if (r_vec == VEC_W'(N_VECS - 1)) begin
                        w_state_nx = ST_DONE;
                        w_busy_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                        w_pass_nx  = (w_err_nx == '0);
                    end else begin
                        w_vec_nx           = r_vec + VEC_W'(1);
                        {w_a_nx, w_b_nx}   = w_vec_nx;
                        w_hold_nx          = '0;
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign a         = r_a;
    assign b         = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign vec_fail  = r_vec_fail;
    assign gate_fail = r_gate_fail;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Scoreboard bench: two checkers (hold 5 and hold 1) driving a fault-injectable gate block.
module tb_gate_vector_checker;

    localparam int unsigned HOLD_A = 5;
    localparam int unsigned HOLD_B = 1;
    localparam int unsigned CNT_W  = 8;

    typedef struct {
        int         c0;
        logic [3:0] vf;
        logic [2:0] err;
        logic [6:0] gf;
        logic       pass;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;

    logic       a0, b0, busy0, done0, pass0;
    logic [2:0] err0;
    logic [3:0] vf0;
    logic [6:0] gf0, c0v;
    logic       a1, b1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [3:0] vf1;
    logic [6:0] gf1, c1v;

    logic [6:0] fmask [4];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit rst_seen = 1'b0;

    exp_t q0[$];
    exp_t q1[$];

    bit   act [2];
    int   drv_c0 [2];

    exp_t       idle_e [2];
    bit         idle_done [2];
    logic [1:0] idle_ab [2];
    bit         m_have, m_pop;
    exp_t       m_hd;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst_n;
    end

    // Truth table from arithmetic on the 0/1 input values.
    function automatic logic [6:0] gate_truth(input int ai, input int bi);
        logic [6:0] r;
        r[0] = (ai * bi) == 1;
        r[1] = (ai + bi) >= 1;
        r[2] = ai == 0;
        r[3] = (ai * bi) == 0;
        r[4] = (ai + bi) == 0;
        r[5] = (ai + bi) == 1;
        r[6] = ai == bi;
        return r;
    endfunction

    always_comb c0v = gate_truth(int'(a0), int'(b0)) ^ fmask[{a0, b0}];
    always_comb c1v = gate_truth(int'(a1), int'(b1)) ^ fmask[{a1, b1}];

    gate_vector_checker #(.HOLD_CYCLES(HOLD_A), .CNT_W(CNT_W)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a0), .b(b0),
        .cand(c0v[0]), .cor(c0v[1]), .cnot(c0v[2]), .cnand(c0v[3]),
        .cnor(c0v[4]), .cxor(c0v[5]), .cxnor(c0v[6]),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .vec_fail(vf0), .gate_fail(gf0)
    );

    gate_vector_checker #(.HOLD_CYCLES(HOLD_B), .CNT_W(CNT_W)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a1), .b(b1),
        .cand(c1v[0]), .cor(c1v[1]), .cnot(c1v[2]), .cnand(c1v[3]),
        .cnor(c1v[4]), .cxor(c1v[5]), .cxnor(c1v[6]),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .vec_fail(vf1), .gate_fail(gf1)
    );

    function automatic int hold_of(input int i);
        return (i == 0) ? int'(HOLD_A) : int'(HOLD_B);
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.c0 = 0; e.vf = '0; e.err = '0; e.gf = '0; e.pass = 1'b0;
        return e;
    endfunction

    // Expected results of a full run from the current fault table.
    function automatic exp_t expect_run(input int t0);
        exp_t e;
        e    = zero_exp();
        e.c0 = t0;
        for (int v = 0; v < 4; v++) begin
            if (fmask[v] != 7'd0) begin
                e.vf[v] = 1'b1;
                e.err   = e.err + 3'd1;
                e.gf    = e.gf | fmask[v];
            end
        end
        e.pass = (e.err == 3'd0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, want, cyc);
        end
    endtask

    task automatic check_inst(input int id, input int h, input bit have, input exp_t hd,
                              input logic busy_o, input logic done_o, input logic pass_o,
                              input logic a_o, input logic b_o, input logic [2:0] err_o,
                              input logic [3:0] vf_o, input logic [6:0] gf_o, output bit popf);
        int    n;
        string p;
        p    = $sformatf("u%0d", id);
        popf = 1'b0;
        if (have) begin
            n = cyc - hd.c0;
            if (n < 4 * h) begin
                chk({p, ".busy"}, 32'(busy_o), 32'd1);
                chk({p, ".done"}, 32'(done_o), 32'd0);
                chk({p, ".ab"},   32'({a_o, b_o}), 32'(n / h));
                if (n == 0) begin
                    chk({p, ".err_clr"},  32'(err_o),  32'd0);
                    chk({p, ".vf_clr"},   32'(vf_o),   32'd0);
                    chk({p, ".gf_clr"},   32'(gf_o),   32'd0);
                    chk({p, ".pass_clr"}, 32'(pass_o), 32'd0);
                end
            end else begin
                chk({p, ".busy_end"}, 32'(busy_o), 32'd0);
                chk({p, ".done_end"}, 32'(done_o), 32'd1);
                chk({p, ".pass"},     32'(pass_o), 32'(hd.pass));
                chk({p, ".err"},      32'(err_o),  32'(hd.err));
                chk({p, ".vec_fail"}, 32'(vf_o),   32'(hd.vf));
                chk({p, ".gate_fail"},32'(gf_o),   32'(hd.gf));
                chk({p, ".ab_end"},   32'({a_o, b_o}), 32'd3);
                idle_e[id]    = hd;
                idle_done[id] = 1'b1;
                idle_ab[id]   = 2'b11;
                popf          = 1'b1;
            end
        end else begin
            chk({p, ".idle_busy"}, 32'(busy_o), 32'd0);
            chk({p, ".idle_done"}, 32'(done_o), 32'(idle_done[id]));
            chk({p, ".idle_pass"}, 32'(pass_o), 32'(idle_e[id].pass));
            chk({p, ".idle_err"},  32'(err_o),  32'(idle_e[id].err));
            chk({p, ".idle_vf"},   32'(vf_o),   32'(idle_e[id].vf));
            chk({p, ".idle_gf"},   32'(gf_o),   32'(idle_e[id].gf));
            chk({p, ".idle_ab"},   32'({a_o, b_o}), 32'(idle_ab[id]));
        end
    endtask

    // Monitor: a reset edge clears the scoreboard, then every output is compared.
    always @(negedge clk) begin
        if (!rst_seen) begin
            q0.delete();
            q1.delete();
            for (int i = 0; i < 2; i++) begin
                idle_e[i]    = zero_exp();
                idle_done[i] = 1'b0;
                idle_ab[i]   = 2'b00;
            end
        end
        m_have = (q0.size() != 0);
        m_hd   = m_have ? q0[0] : zero_exp();
        check_inst(0, int'(HOLD_A), m_have, m_hd, busy0, done0, pass0, a0, b0, err0, vf0, gf0, m_pop);
        if (m_pop) void'(q0.pop_front());
        m_have = (q1.size() != 0);
        m_hd   = m_have ? q1[0] : zero_exp();
        check_inst(1, int'(HOLD_B), m_have, m_hd, busy1, done1, pass1, a1, b1, err1, vf1, gf1, m_pop);
        if (m_pop) void'(q1.pop_front());
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rst_n && !(act[i] && (cyc - drv_c0[i]) <= 4 * hold_of(i))) begin
                act[i]    = 1'b1;
                drv_c0[i] = cyc;
                if (i == 0) q0.push_back(expect_run(cyc));
                else        q1.push_back(expect_run(cyc));
            end
        end
        start = 1'b0;
    endtask

    task automatic do_reset(input bit with_start);
        @(negedge clk);
        rst_n = 1'b0;
        start = with_start;
        @(posedge clk);
        #1;
        act[0] = 1'b0;
        act[1] = 1'b0;
        start  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 500; k++) begin
            if (!((act[0] && (cyc - drv_c0[0]) <= 4 * hold_of(0)) ||
                  (act[1] && (cyc - drv_c0[1]) <= 4 * hold_of(1)))) break;
            @(posedge clk);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic set_clean();
        for (int v = 0; v < 4; v++) fmask[v] = 7'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] t;
        int mode;
        rst_n  = 1'b0;
        start  = 1'b0;
        act[0] = 1'b0;
        act[1] = 1'b0;
        drv_c0[0] = 0;
        drv_c0[1] = 0;
        set_clean();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Clean run, then a run with extra start pulses that must be ignored.
        pulse_start();
        wait_idle();
        pulse_start();
        repeat (2) @(posedge clk);
        pulse_start();
        repeat (6) @(posedge clk);
        pulse_start();
        wait_idle();

        // XOR output forced low.
        for (int v = 0; v < 4; v++) begin
            t = gate_truth(v / 2, v % 2);
            fmask[v] = t[5] ? 7'b0100000 : 7'd0;
        end
        pulse_start();
        wait_idle();

        // AND output stuck high.
        for (int v = 0; v < 4; v++) begin
            t = gate_truth(v / 2, v % 2);
            fmask[v] = t[0] ? 7'd0 : 7'b0000001;
        end
        pulse_start();
        wait_idle();

        // Restart from DONE after a failing run with a correct gate block.
        set_clean();
        pulse_start();
        wait_idle();

        // Reset in the middle of vector 01, then a clean full run.
        for (int v = 0; v < 4; v++) fmask[v] = 7'($urandom_range(0, 127));
        pulse_start();
        repeat (6) @(posedge clk);
        do_reset(1'b0);
        set_clean();
        pulse_start();
        wait_idle();

        // Start coincident with reset: reset wins.
        do_reset(1'b1);
        repeat (2) @(negedge clk);

        for (int it = 0; it < 12; it++) begin
            for (int v = 0; v < 4; v++)
                fmask[v] = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
            pulse_start();
            mode = int'($urandom_range(0, 3));
            if (mode == 0) begin
                repeat ($urandom_range(1, 18)) @(posedge clk);
                do_reset(1'($urandom_range(0, 1)));
            end else if (mode == 1) begin
                for (int j = 0; j < 2; j++) begin
                    repeat ($urandom_range(0, 8)) @(negedge clk);
                    pulse_start();
                end
            end
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
